alu_op_sequencer: RTL and testbench

//  Parametrised successor to the combinational ALU-control decode. Decodes funct/ALUop

---
 rtl/alu_op_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Decodes funct/ALUop to an op code and executes it: add/sub/move/swap in one cycle,
// mult/div iteratively over WIDTH cycles. Define ALU_SEQ_OVF_EN to add the signed-overflow port ovf.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
`ifdef ALU_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             op_err
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpMul  = 4'b0010;
    localparam logic [3:0] OpDiv  = 4'b0011;
    localparam logic [3:0] OpMove = 4'b0100;
    localparam logic [3:0] OpSwap = 4'b0101;
    localparam logic [3:0] OpNop  = 4'b1111;

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [3:0]       dec_op;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        dec_op = OpNop;
        if (alu_op == 2'b11) begin
            case (funct)
                4'b0000: dec_op = OpAdd;
                4'b0010: dec_op = OpSub;
                4'b0100: dec_op = OpMul;
                4'b0101: dec_op = OpDiv;
                4'b0111: dec_op = OpMove;
                4'b1000: dec_op = OpSwap;
                default: dec_op = OpNop;
            endcase
        end
    end

    always_comb begin
        add_sum   = {1'b0, op_a} + {1'b0, op_b};
        sub_diff  = {1'b0, op_a} - {1'b0, op_b};
        // Multiply: lo holds the not-yet-consumed multiplier bits, hi the running partial sum.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        // Divide: hi is the partial remainder, quotient bits shift into lo from the right.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef ALU_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = dec_op;
                    b_d     = op_b;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StDone;
`ifdef ALU_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    case (dec_op)
                        OpAdd: begin
                            lo_d = add_sum[WIDTH-1:0];
                            hi_d = {{(WIDTH - 1){1'b0}}, add_sum[WIDTH]};
`ifdef ALU_SEQ_OVF_EN
                            ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
                        end
                        OpSub: begin
                            lo_d = sub_diff[WIDTH-1:0];
                            hi_d = {{(WIDTH - 1){1'b0}}, sub_diff[WIDTH]};
`ifdef ALU_SEQ_OVF_EN
                            ovf_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                    (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
`endif
                        end
                        OpMul: begin
                            lo_d    = op_a;
                            hi_d    = '0;
                            cnt_d   = CntW'(WIDTH - 1);
                            state_d = StBusy;
                        end
                        OpDiv: begin
                            if (op_b == '0) begin
                                lo_d  = '1;
                                hi_d  = op_a;
                                err_d = 1'b1;
                            end else begin
                                lo_d    = op_a;
                                hi_d    = '0;
                                cnt_d   = CntW'(WIDTH - 1);
                                state_d = StBusy;
                            end
                        end
                        OpMove: begin
                            lo_d = op_b;
                            hi_d = '0;
                        end
                        OpSwap: begin
                            lo_d = op_b;
                            hi_d = op_a;
                        end
                        default: begin
                            lo_d  = '0;
                            hi_d  = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            StBusy: begin
                if (op_q == OpMul) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            b_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign operation = op_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign op_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (WIDTH=8): directed steps with a scoreboard of
// expected results built from a reference model at request time.
module tb_alu_op_sequencer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   funct;
    logic [1:0]   alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   operation;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         op_err;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operation (operation),
        .result_lo (result_lo),
        .result_hi (result_hi),
`ifdef ALU_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         err;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] aop, input logic [3:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         m;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        m.err = 1'b0;
        m.ovf = 1'b0;
        m.lat = 1;
        m.lo  = '0;
        m.hi  = '0;
        m.op  = 4'hf;
        if (aop == 2'b11) begin
            case (f)
                4'h0: m.op = 4'h0;
                4'h2: m.op = 4'h1;
                4'h4: m.op = 4'h2;
                4'h5: m.op = 4'h3;
                4'h7: m.op = 4'h4;
                4'h8: m.op = 4'h5;
                default: m.op = 4'hf;
            endcase
        end
        case (m.op)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                m.lo = s[W-1:0];
                m.hi = {7'd0, s[W]};
                m.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'h1: begin
                m.lo = a - b;
                m.hi = (a < b) ? 8'd1 : 8'd0;
                m.ovf = (a[W-1] != b[W-1]) && (m.lo[W-1] != a[W-1]);
            end
            4'h2: begin
                p = {8'd0, a} * {8'd0, b};
                m.lo = p[W-1:0];
                m.hi = p[2*W-1:W];
                m.lat = W + 1;
            end
            4'h3: begin
                if (b == '0) begin
                    m.lo = 8'hff;
                    m.hi = a;
                    m.err = 1'b1;
                end else begin
                    m.lo = a / b;
                    m.hi = a % b;
                    m.lat = W + 1;
                end
            end
            4'h4: m.lo = b;
            4'h5: begin
                m.lo = b;
                m.hi = a;
            end
            default: m.err = 1'b1;
        endcase
        return m;
    endfunction

    // Entered #1 after a rising edge with the sequencer idle; leaves it idle again.
    task automatic run(input logic [1:0] aop, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input string tag);
        exp_t e;
        int   cyc;
        check({tag, " in_ready idle"}, in_ready, 1);
        alu_op   = aop;
        funct    = f;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        sb.push_back(model(aop, f, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        funct    = ~f;
        cyc      = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            check({tag, " in_ready busy"}, in_ready, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " out_valid"}, out_valid, 1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check({tag, " latency"}, cyc, e.lat);
            for (int i = 0; i <= hold; i++) begin
                check({tag, " operation"}, operation, e.op);
                check({tag, " result_lo"}, result_lo, e.lo);
                check({tag, " result_hi"}, result_hi, e.hi);
                check({tag, " op_err"}, op_err, e.err);
`ifdef ALU_SEQ_OVF_EN
                check({tag, " ovf"}, ovf, e.ovf);
`endif
                check({tag, " in_ready done"}, in_ready, 0);
                check({tag, " out_valid held"}, out_valid, 1);
                if (i < hold) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released"}, out_valid, 0);
        check({tag, " in_ready after"}, in_ready, 1);
    endtask

    logic [3:0] flist [6];

    initial begin
        flist     = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h8};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct     = '0;
        alu_op    = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset operation", operation, 4'hf);
        check("reset result_lo", result_lo, 0);
        check("reset result_hi", result_hi, 0);
        check("reset op_err", op_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(2'b11, 4'h0, 8'hf0, 8'h20, 0, "T1 add");
        run(2'b11, 4'h4, 8'hff, 8'hff, 0, "T2 mult");
        run(2'b11, 4'h5, 8'd200, 8'd7, 0, "T3 div");
        run(2'b11, 4'h5, 8'd200, 8'd0, 0, "T3 div0");
        run(2'b11, 4'h2, 8'h10, 8'h30, 5, "T4 sub backpressure");
        run(2'b11, 4'h4, 8'h0d, 8'hb3, 5, "T4 mult backpressure");

        // Reset during the fourth BUSY cycle of a multiply; the pending result is dropped.
        alu_op   = 2'b11;
        funct    = 4'h4;
        op_a     = 8'hff;
        op_b     = 8'hff;
        in_valid = 1'b1;
        sb.push_back(model(2'b11, 4'h4, 8'hff, 8'hff));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("T5 busy in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("T5 rst out_valid", out_valid, 0);
        check("T5 rst result_lo", result_lo, 0);
        check("T5 rst result_hi", result_hi, 0);
        check("T5 rst operation", operation, 4'hf);
        check("T5 rst op_err", op_err, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("T5 no stale out_valid", out_valid, 0);
        run(2'b11, 4'h8, 8'h12, 8'h34, 0, "T5 swap");

        run(2'b10, 4'h0, 8'h55, 8'h66, 0, "T6 aluop10");
        run(2'b11, 4'hf, 8'h55, 8'h66, 0, "T6 funct1111");
        run(2'b11, 4'h0, 8'h70, 8'h10, 0, "T6 add ovf");
        run(2'b11, 4'h2, 8'h80, 8'h01, 0, "sub ovf");
        run(2'b11, 4'h7, 8'h9a, 8'hbc, 0, "move");
        run(2'b11, 4'h5, 8'h05, 8'h09, 0, "div small");

        for (int i = 0; i < 10; i++) begin
            run(2'b11, flist[$urandom_range(0, 5)], 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
